// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter and APB master sequencer sharing one APB slave among NREQ requesters.
// Optional ACCESS-phase timeout is enabled by defining APB_ARB_TIMEOUT_EN.
module apb_master_arbiter #(
    parameter int NREQ        = 2,
    parameter int AW          = 32,
    parameter int DW          = 8,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ-1:0]    req_write,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]    req_ack,
    output logic [NREQ-1:0]    rsp_valid,
    output logic [DW-1:0]      rsp_rdata,
    output logic               rsp_err,
    output logic               psel,
    output logic               penable,
    output logic               pwrite,
    output logic [AW-1:0]      paddr,
    output logic [DW-1:0]      pwdata,
    input  logic [DW-1:0]      prdata,
    input  logic               pready,
    input  logic               pslverr
);
    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t        state;
    logic [GW-1:0] last_grant;
    logic [GW-1:0] gnt_idx;
    logic          gnt_any;
    logic          sel_write;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

`ifdef APB_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tmo_cnt;
`else
    logic [31:0] unused_tmo;
    assign unused_tmo = 32'(TIMEOUT_CYC);
`endif

    // First pass looks above last_grant, second pass wraps to the lowest index.
    always_comb begin
        gnt_any   = 1'b0;
        gnt_idx   = '0;
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!gnt_any && req_valid[i] && (GW'(i) > last_grant)) begin
                gnt_any   = 1'b1;
                gnt_idx   = GW'(i);
                sel_write = req_write[i];
                sel_addr  = req_addr[i*AW +: AW];
                sel_wdata = req_wdata[i*DW +: DW];
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!gnt_any && req_valid[i]) begin
                gnt_any   = 1'b1;
                gnt_idx   = GW'(i);
                sel_write = req_write[i];
                sel_addr  = req_addr[i*AW +: AW];
                sel_wdata = req_wdata[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state      <= IDLE;
            last_grant <= GW'(NREQ - 1);
            req_ack    <= '0;
            rsp_valid  <= '0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
            psel       <= 1'b0;
            penable    <= 1'b0;
            pwrite     <= 1'b0;
            paddr      <= '0;
            pwdata     <= '0;
`ifdef APB_ARB_TIMEOUT_EN
            tmo_cnt    <= '0;
`endif
        end else begin
            req_ack   <= '0;
            rsp_valid <= '0;
            case (state)
                IDLE: begin
                    rsp_rdata <= '0;
                    rsp_err   <= 1'b0;
                    if (gnt_any) begin
                        req_ack[gnt_idx] <= 1'b1;
                        last_grant       <= gnt_idx;
                        pwrite           <= sel_write;
                        paddr            <= sel_addr;
                        pwdata           <= sel_wdata;
                        psel             <= 1'b1;
                        penable          <= 1'b0;
                        state            <= SETUP;
                    end
                end
                SETUP: begin
                    penable <= 1'b1;
`ifdef APB_ARB_TIMEOUT_EN
                    tmo_cnt <= '0;
`endif
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (pready) begin
                        psel                  <= 1'b0;
                        penable               <= 1'b0;
                        rsp_valid[last_grant] <= 1'b1;
                        rsp_err               <= pslverr;
                        rsp_rdata             <= (!pwrite && !pslverr) ? prdata : '0;
                        state                 <= IDLE;
                    end
`ifdef APB_ARB_TIMEOUT_EN
                    else if (tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
                        psel                  <= 1'b0;
                        penable               <= 1'b0;
                        rsp_valid[last_grant] <= 1'b1;
                        rsp_err               <= 1'b1;
                        rsp_rdata             <= '0;
                        state                 <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
